axis_rr_arbiter: RTL and testbench



---
 rtl/axis_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-granular round-robin arbiter sharing one registered AXI-Stream master among NUM_IN slaves.
// Optional feature macro AXIS_ARB_TID_TAG_EN: master TID carries the granted port index instead of the slave TID.
module axis_rr_arbiter #(
    parameter int NUM_IN = 4,
    parameter int DATAW  = 32,
    parameter int IDW    = 4,
    parameter int USERW  = 4,
    parameter int DESTW  = 4
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [NUM_IN-1:0]         AXIS_S_TVALID,
    output logic [NUM_IN-1:0]         AXIS_S_TREADY,
    input  logic [NUM_IN*DATAW-1:0]   AXIS_S_TDATA,
    input  logic [NUM_IN-1:0]         AXIS_S_TLAST,
    input  logic [NUM_IN*IDW-1:0]     AXIS_S_TID,
    input  logic [NUM_IN*USERW-1:0]   AXIS_S_TUSER,
    input  logic [NUM_IN*DESTW-1:0]   AXIS_S_TDEST,
    output logic                      AXIS_M_TVALID,
    input  logic                      AXIS_M_TREADY,
    output logic [DATAW-1:0]          AXIS_M_TDATA,
    output logic                      AXIS_M_TLAST,
    output logic [IDW-1:0]            AXIS_M_TID,
    output logic [USERW-1:0]          AXIS_M_TUSER,
    output logic [DESTW-1:0]          AXIS_M_TDEST,
    output logic                      GRANT_VALID,
    output logic [$clog2(NUM_IN)-1:0] GRANT_IDX
);
    localparam int GW = $clog2(NUM_IN);
    localparam logic [GW-1:0] LAST_PORT = GW'(NUM_IN - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state_q, state_d;
    logic [GW-1:0] grant_idx_q, grant_idx_d, last_grant_q, last_grant_d, pick, cand;
    logic found, accept;
    logic m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
    logic [DATAW-1:0] m_tdata_q, m_tdata_d;
    logic [IDW-1:0] m_tid_q, m_tid_d;
    logic [USERW-1:0] m_tuser_q, m_tuser_d;
    logic [DESTW-1:0] m_tdest_q, m_tdest_d;

`ifdef AXIS_ARB_TID_TAG_EN
    if (IDW < GW) begin : g_idw_check
        $error("axis_rr_arbiter: IDW too narrow to carry the port index");
    end
`endif

    // Rotating priority scan: first requester after last_grant wins
    always_comb begin
        pick = last_grant_q;
        cand = last_grant_q;
        found = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            cand = (cand == LAST_PORT) ? '0 : cand + 1'b1;
            if (!found && AXIS_S_TVALID[cand]) begin
                pick = cand;
                found = 1'b1;
            end
        end
    end

    // FSM state and grant registers; reset gives port 0 first priority
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            grant_idx_q <= '0;
            last_grant_q <= LAST_PORT;
        end else begin
            state_q <= state_d;
            grant_idx_q <= grant_idx_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next state: grant in IDLE, release after the TLAST beat is accepted
    always_comb begin
        state_d = state_q;
        grant_idx_d = grant_idx_q;
        last_grant_d = last_grant_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = BUSY;
                grant_idx_d = pick;
            end
        end else if (accept && AXIS_S_TLAST[grant_idx_q]) begin
            state_d = IDLE;
            last_grant_d = grant_idx_q;
        end
    end

    // FSM outputs: only the granted port sees ready, and only when the output slot frees up
    always_comb begin
        GRANT_VALID = state_q == BUSY;
        AXIS_S_TREADY = '0;
        AXIS_S_TREADY[grant_idx_q] = GRANT_VALID && (!m_tvalid_q || AXIS_M_TREADY);
        accept = AXIS_S_TREADY[grant_idx_q] && AXIS_S_TVALID[grant_idx_q];
    end

    // Output stage: load on accept, otherwise hold the beat until it drains
    always_comb begin
        m_tvalid_d = accept ? 1'b1 : (AXIS_M_TREADY ? 1'b0 : m_tvalid_q);
        m_tdata_d  = accept ? AXIS_S_TDATA[int'(grant_idx_q)*DATAW +: DATAW] : m_tdata_q;
        m_tlast_d  = accept ? AXIS_S_TLAST[grant_idx_q] : m_tlast_q;
`ifdef AXIS_ARB_TID_TAG_EN
        m_tid_d    = accept ? IDW'(grant_idx_q) : m_tid_q;
`else
        m_tid_d    = accept ? AXIS_S_TID[int'(grant_idx_q)*IDW +: IDW] : m_tid_q;
`endif
        m_tuser_d  = accept ? AXIS_S_TUSER[int'(grant_idx_q)*USERW +: USERW] : m_tuser_q;
        m_tdest_d  = accept ? AXIS_S_TDEST[int'(grant_idx_q)*DESTW +: DESTW] : m_tdest_q;
    end

    // Output register; reset discards any in-flight beat
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q <= '0;
            m_tlast_q <= 1'b0;
            m_tid_q <= '0;
            m_tuser_q <= '0;
            m_tdest_q <= '0;
        end else begin
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q <= m_tdata_d;
            m_tlast_q <= m_tlast_d;
            m_tid_q <= m_tid_d;
            m_tuser_q <= m_tuser_d;
            m_tdest_q <= m_tdest_d;
        end
    end

    assign AXIS_M_TVALID = m_tvalid_q;
    assign AXIS_M_TDATA = m_tdata_q;
    assign AXIS_M_TLAST = m_tlast_q;
    assign AXIS_M_TID = m_tid_q;
    assign AXIS_M_TUSER = m_tuser_q;
    assign AXIS_M_TDEST = m_tdest_q;
    assign GRANT_IDX = grant_idx_q;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed scenarios plus randomized traffic against a behavioural arbiter model.
module tb_axis_rr_arbiter;
    localparam int N = 4, DW = 32, IW = 4, UW = 4, TW = 4;
`ifdef AXIS_ARB_TID_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] d;
        logic l;
        logic [IW-1:0] id;
        logic [UW-1:0] u;
        logic [TW-1:0] t;
    } beat_t;

    logic clk = 1'b0, rst_n = 1'b1;
    logic [N-1:0] s_tvalid = '0, s_tlast = '0, hold = '0, acc_mask = '0;
    logic [N-1:0] s_tready;
    logic [N*DW-1:0] s_tdata = '0;
    logic [N*IW-1:0] s_tid = '0;
    logic [N*UW-1:0] s_tuser = '0;
    logic [N*TW-1:0] s_tdest = '0;
    logic m_tready = 1'b1;
    logic m_tvalid, m_tlast, gv;
    logic [DW-1:0] m_tdata;
    logic [IW-1:0] m_tid;
    logic [UW-1:0] m_tuser;
    logic [TW-1:0] m_tdest;
    logic [1:0] gi;
    int checks = 0, errors = 0, cyc = 0;
    beat_t q[N][$];
    beat_t out_log[$];
    int out_cyc[$];

    axis_rr_arbiter #(.NUM_IN(N), .DATAW(DW), .IDW(IW), .USERW(UW), .DESTW(TW)) dut (
        .CLK(clk), .RST_N(rst_n),
        .AXIS_S_TVALID(s_tvalid), .AXIS_S_TREADY(s_tready), .AXIS_S_TDATA(s_tdata),
        .AXIS_S_TLAST(s_tlast), .AXIS_S_TID(s_tid), .AXIS_S_TUSER(s_tuser), .AXIS_S_TDEST(s_tdest),
        .AXIS_M_TVALID(m_tvalid), .AXIS_M_TREADY(m_tready), .AXIS_M_TDATA(m_tdata),
        .AXIS_M_TLAST(m_tlast), .AXIS_M_TID(m_tid), .AXIS_M_TUSER(m_tuser), .AXIS_M_TDEST(m_tdest),
        .GRANT_VALID(gv), .GRANT_IDX(gi)
    );

    always #5 clk = ~clk;

    // Reference model: packet-level round robin with a single output slot
    logic e_busy = 1'b0, e_mv = 1'b0, e_l = 1'b0;
    int e_grant = 0, e_last = N - 1;
    logic [DW-1:0] e_d = '0;
    logic [IW-1:0] e_id = '0;
    logic [UW-1:0] e_u = '0;
    logic [TW-1:0] e_t = '0;
    wire e_go = e_busy && (!e_mv || m_tready);
    wire [N-1:0] e_rdy = e_go ? N'(32'd1 << e_grant) : '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_busy <= 1'b0; e_mv <= 1'b0; e_grant <= 0; e_last <= N - 1;
            e_d <= '0; e_l <= 1'b0; e_id <= '0; e_u <= '0; e_t <= '0;
        end else begin
            if (e_go && s_tvalid[e_grant]) begin
                e_mv <= 1'b1;
                e_d <= s_tdata[e_grant*DW +: DW];
                e_l <= s_tlast[e_grant];
                e_id <= TAG ? IW'(e_grant) : s_tid[e_grant*IW +: IW];
                e_u <= s_tuser[e_grant*UW +: UW];
                e_t <= s_tdest[e_grant*TW +: TW];
                if (s_tlast[e_grant]) begin
                    e_busy <= 1'b0;
                    e_last <= e_grant;
                end
            end else if (m_tready) begin
                e_mv <= 1'b0;
            end
            if (!e_busy)
                for (int d = N; d >= 1; d--)
                    if (s_tvalid[(e_last + d) % N]) begin
                        e_busy <= 1'b1;
                        e_grant <= (e_last + d) % N;
                    end
        end
    end

    // Edge-sampled handshakes and output-beat log
    always @(posedge clk) begin
        acc_mask <= s_tvalid & s_tready;
        cyc <= cyc + 1;
        if (m_tvalid && m_tready) begin
            out_log.push_back('{d: m_tdata, l: m_tlast, id: m_tid, u: m_tuser, t: m_tdest});
            out_cyc.push_back(cyc);
        end
    end

    // Producers: each port presents the head of its queue
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i] && q[i].size() > 0) void'(q[i].pop_front());
            s_tvalid[i] = q[i].size() > 0 && !hold[i];
            if (q[i].size() > 0) begin
                s_tdata[i*DW +: DW] = q[i][0].d;
                s_tlast[i] = q[i][0].l;
                s_tid[i*IW +: IW] = q[i][0].id;
                s_tuser[i*UW +: UW] = q[i][0].u;
                s_tdest[i*TW +: TW] = q[i][0].t;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_pkt(input int p, input int len, input logic [DW-1:0] base, input logic [IW-1:0] id);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d = base + DW'(k);
            b.l = (k == len - 1);
            b.id = id;
            b.u = UW'(p);
            b.t = TW'(k + 1);
            q[p].push_back(b);
        end
    endtask

    task automatic flush;
        for (int i = 0; i < N; i++) q[i].delete();
        hold = '0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        flush();
        m_tready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tlast !== 1'b0 || m_tid !== '0 || m_tuser !== '0 || m_tdest !== '0)
            begin errors++; $display("FAIL reset_m_outputs valid=%b data=%h last=%b id=%h want all 0", m_tvalid, m_tdata, m_tlast, m_tid); end
        checks++; if (gv !== 1'b0 || gi !== 2'd0) begin errors++; $display("FAIL reset_grant gv=%b gi=%0d want 0/0", gv, gi); end
        checks++; if (s_tready !== 4'b0) begin errors++; $display("FAIL reset_tready got=%b want 0000", s_tready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (gv !== 1'b0 || m_tvalid !== 1'b0 || s_tready !== 4'b0)
            begin errors++; $display("FAIL reset_release gv=%b mv=%b rdy=%b want 0", gv, m_tvalid, s_tready); end
    endtask

    task automatic test_single_packet;
        do_reset();
        @(negedge clk);
        push_pkt(2, 3, 32'hA0, 4'h0);
        @(negedge clk);
        checks++; if (gv !== 1'b0) begin errors++; $display("FAIL single_c0_gv got=%b want 0", gv); end
        @(negedge clk);
        checks++; if (gv !== 1'b1 || gi !== 2'd2) begin errors++; $display("FAIL single_c1_grant gv=%b gi=%0d want 1/2", gv, gi); end
        checks++; if (s_tready !== 4'b0100) begin errors++; $display("FAIL single_c1_tready got=%b want 0100", s_tready); end
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'hA0 + 32'(c - 2) || m_tlast !== (c == 4))
                begin errors++; $display("FAIL single_beat_c%0d mv=%b data=%h last=%b want 1/%h/%b", c, m_tvalid, m_tdata, m_tlast, 32'hA0 + 32'(c - 2), c == 4); end
        end
        checks++; if (gv !== 1'b0) begin errors++; $display("FAIL single_release gv=%b want 0", gv); end
        @(negedge clk);
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_drain mv=%b want 0", m_tvalid); end
    endtask

    task automatic test_rr_fairness;
        int n;
        do_reset();
        @(negedge clk);
        out_log.delete();
        out_cyc.delete();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < N; p++) push_pkt(p, 1, 32'h100 + 32'(p * 16 + k), 4'h0);
        for (int t = 0; t < 60 && out_log.size() < 8; t++) @(negedge clk);
        checks++; if (out_log.size() < 8) begin errors++; $display("FAIL rr_count got=%0d want 8", out_log.size()); end
        n = out_log.size() < 8 ? out_log.size() : 8;
        for (int i = 0; i < n; i++) begin
            checks++; if (int'(out_log[i].d[7:4]) != i % N)
                begin errors++; $display("FAIL rr_order beat%0d port=%0d want %0d", i, out_log[i].d[7:4], i % N); end
            if (i > 0) begin
                checks++; if (out_cyc[i] - out_cyc[i-1] != 2)
                    begin errors++; $display("FAIL rr_spacing beat%0d gap=%0d want 2", i, out_cyc[i] - out_cyc[i-1]); end
            end
        end
    endtask

    task automatic test_backpressure;
        int t;
        @(negedge clk);
        out_log.delete();
        push_pkt(1, 4, 32'hB0, 4'h0);
        for (t = 0; t < 10 && !(m_tvalid && m_tdata == 32'hB0); t++) @(negedge clk);
        checks++; if (t == 10) begin errors++; $display("FAIL bp_first_beat not seen, mv=%b data=%h want B0", m_tvalid, m_tdata); end
        m_tready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'hB0 || m_tlast !== 1'b0)
                begin errors++; $display("FAIL bp_hold cyc%0d mv=%b data=%h want 1/B0", c, m_tvalid, m_tdata); end
            checks++; if (s_tready[1] !== 1'b0) begin errors++; $display("FAIL bp_tready cyc%0d got=%b want 0", c, s_tready[1]); end
        end
        m_tready = 1'b1;
        for (t = 0; t < 20 && out_log.size() < 4; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++; if (out_log.size() != 4) begin errors++; $display("FAIL bp_count got=%0d want 4", out_log.size()); end
        for (int i = 0; i < 4 && i < out_log.size(); i++) begin
            checks++; if (out_log[i].d !== 32'hB0 + 32'(i) || out_log[i].l !== (i == 3))
                begin errors++; $display("FAIL bp_beat%0d data=%h last=%b want %h/%b", i, out_log[i].d, out_log[i].l, 32'hB0 + 32'(i), i == 3); end
        end
    endtask

    task automatic test_stall;
        logic [DW-1:0] want [4];
        want = '{32'hC0, 32'hC1, 32'hC2, 32'hD0};
        do_reset();
        @(negedge clk);
        out_log.delete();
        push_pkt(0, 3, 32'hC0, 4'h0);
        push_pkt(3, 1, 32'hD0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        checks++; if (gv !== 1'b1 || gi !== 2'd0) begin errors++; $display("FAIL stall_grant gv=%b gi=%0d want 1/0", gv, gi); end
        hold[0] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (gv !== 1'b1 || gi !== 2'd0 || s_tready[3] !== 1'b0)
                begin errors++; $display("FAIL stall_hold cyc%0d gv=%b gi=%0d rdy3=%b want 1/0/0", c, gv, gi, s_tready[3]); end
        end
        hold[0] = 1'b0;
        for (int t = 0; t < 30 && out_log.size() < 4; t++) @(negedge clk);
        checks++; if (out_log.size() != 4) begin errors++; $display("FAIL stall_count got=%0d want 4", out_log.size()); end
        for (int i = 0; i < 4 && i < out_log.size(); i++) begin
            checks++; if (out_log[i].d !== want[i]) begin errors++; $display("FAIL stall_order beat%0d data=%h want %h", i, out_log[i].d, want[i]); end
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        @(negedge clk);
        push_pkt(1, 4, 32'hE0, 4'h0);
        repeat (4) @(negedge clk);
        checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'hE1) begin errors++; $display("FAIL rstmid_pre mv=%b data=%h want 1/E1", m_tvalid, m_tdata); end
        rst_n = 1'b0;
        #1;
        checks++; if (m_tvalid !== 1'b0 || m_tdata !== '0) begin errors++; $display("FAIL rstmid_out mv=%b data=%h want 0/0", m_tvalid, m_tdata); end
        checks++; if (gv !== 1'b0 || s_tready !== 4'b0) begin errors++; $display("FAIL rstmid_grant gv=%b rdy=%b want 0/0000", gv, s_tready); end
        flush();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_log.delete();
        @(negedge clk);
        push_pkt(1, 1, 32'hF1, 4'h0);
        push_pkt(0, 1, 32'hF0, 4'h0);
        repeat (2) @(negedge clk);
        checks++; if (gv !== 1'b1 || gi !== 2'd0) begin errors++; $display("FAIL rstmid_regrant gv=%b gi=%0d want 1/0", gv, gi); end
        for (int t = 0; t < 20 && out_log.size() < 2; t++) @(negedge clk);
        checks++; if (out_log.size() != 2 || out_log[0].d !== 32'hF0 || out_log[1].d !== 32'hF1)
            begin errors++; $display("FAIL rstmid_order count=%0d want F0 then F1", out_log.size()); end
    endtask

    task automatic test_tid;
        logic [IW-1:0] want_id;
        want_id = TAG ? 4'h3 : 4'h5;
        @(negedge clk);
        out_log.delete();
        push_pkt(3, 1, 32'h3D, 4'h5);
        for (int t = 0; t < 20 && out_log.size() < 1; t++) @(negedge clk);
        checks++; if (out_log.size() != 1) begin errors++; $display("FAIL tid_count got=%0d want 1", out_log.size()); end
        else begin
            checks++; if (out_log[0].id !== want_id) begin errors++; $display("FAIL tid_value got=%h want %h", out_log[0].id, want_id); end
            checks++; if (out_log[0].d !== 32'h3D || out_log[0].u !== 4'h3 || out_log[0].t !== 4'h1 || out_log[0].l !== 1'b1)
                begin errors++; $display("FAIL tid_payload data=%h user=%h dest=%h last=%b want 3D/3/1/1", out_log[0].d, out_log[0].u, out_log[0].t, out_log[0].l); end
        end
    endtask

    task automatic test_random;
        int pushed = 0, p, len, t;
        @(negedge clk);
        out_log.delete();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            checks++; if (gv !== e_busy || gi !== 2'(e_grant))
                begin errors++; $display("FAIL rand_grant cyc%0d gv=%b gi=%0d want %b/%0d", c, gv, gi, e_busy, e_grant); end
            checks++; if (s_tready !== e_rdy) begin errors++; $display("FAIL rand_tready cyc%0d got=%b want %b", c, s_tready, e_rdy); end
            checks++; if (m_tvalid !== e_mv) begin errors++; $display("FAIL rand_mvalid cyc%0d got=%b want %b", c, m_tvalid, e_mv); end
            if (e_mv) begin
                checks++; if ({m_tdata, m_tlast, m_tid, m_tuser, m_tdest} !== {e_d, e_l, e_id, e_u, e_t})
                    begin errors++; $display("FAIL rand_payload cyc%0d data=%h last=%b id=%h want %h/%b/%h", c, m_tdata, m_tlast, m_tid, e_d, e_l, e_id); end
            end
            if ($urandom_range(0, 2) == 0) begin
                p = int'($urandom_range(0, N - 1));
                len = int'($urandom_range(1, 4));
                if (q[p].size() < 10) begin
                    push_pkt(p, len, $urandom, IW'($urandom_range(0, 15)));
                    pushed += len;
                end
            end
            hold = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            m_tready = $urandom_range(0, 3) != 0;
        end
        hold = '0;
        m_tready = 1'b1;
        for (t = 0; t < 600 && (q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0 || m_tvalid || gv); t++) @(negedge clk);
        checks++; if (t == 600) begin errors++; $display("FAIL rand_drain timeout gv=%b mv=%b", gv, m_tvalid); end
        checks++; if (out_log.size() != pushed) begin errors++; $display("FAIL rand_beats got=%0d want %0d", out_log.size(), pushed); end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_rr_fairness();
        test_backpressure();
        test_stall();
        test_reset_mid();
        test_tid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
